// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pll_lock_supervisor_if
//  Brief    : PLL reset/lock and downstream-reset signal bundle for the
//             PLL lock supervisor.
//  Revision : 1.0 - initial release
// ============================================================================
interface pll_lock_supervisor_if;
    logic       locked_in;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic       lock_lost;

    // master: the supervisor itself; slave: the PLL / downstream side
    modport master (
        input  locked_in,
        output pll_rst, sys_reset, ready, fail, retry_count, lock_lost
    );

    modport slave (
        output locked_in,
        input  pll_rst, sys_reset, ready, fail, retry_count, lock_lost
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pll_lock_supervisor
//  Brief    : Pulses PLL reset, waits for a stable lock with timeout/retry,
//             then releases the downstream system reset.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  wire logic             refclk,
    input  wire logic             rst,
    pll_lock_supervisor_if.master bus
);

    localparam int c_cnt_max_a = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                 RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_cnt_max   = (c_cnt_max_a > STABLE_CYCLES) ? c_cnt_max_a : STABLE_CYCLES;
    localparam int c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(RST_PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    localparam logic [3:0]         c_max_retries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic                   lost_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_rst_q;
    logic                   sys_reset_q;
    logic                   ready_q;
    logic                   fail_q;
    logic                   lock_lost_q;

    logic                   w_lock_sync;
    logic [3:0]             w_retry_inc;

    // locked_in is asynchronous to refclk; only the last stage feeds the FSM
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
        end
    end

    assign w_lock_sync = sync_q[SYNC_STAGES-1];
    assign w_retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        unique case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == c_rst_last) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_WAIT_LOCK: begin
                // a lock seen on the timeout cycle still counts as a lock
                if (w_lock_sync) begin
                    cnt_d   = '0;
                    state_d = ST_STABILIZE;
                end else if (cnt_q == c_timeout_last) begin
                    cnt_d   = '0;
                    retry_d = w_retry_inc;
                    state_d = (w_retry_inc == c_max_retries) ? ST_FAIL : ST_PLL_RESET;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_sync) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == c_stable_last) begin
                    cnt_d   = '0;
                    retry_d = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_RUN: begin
                if (!w_lock_sync) begin
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                    state_d = ST_PLL_RESET;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_PLL_RESET;
            end
        endcase
    end

    // outputs are decoded from the next state so they change on the same edge
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
            lock_lost_q <= lost_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_q;
    assign bus.lock_lost   = lock_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pll_lock_supervisor
//  Brief    : Directed scoreboard bench for pll_lock_supervisor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    int         edge_n;
    int         n_checks;
    int         n_pass;
    exp_t       sb[$];
    logic [8:0] w_obs;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (100),
        .STABLE_CYCLES       (8),
        .MAX_RETRIES         (3),
        .SYNC_STAGES         (2)
    ) dut (
        .refclk (clk),
        .rst    (rst),
        .bus    (bus.master)
    );

    // {pll_rst, sys_reset, ready, fail, retry_count[3:0], lock_lost}
    assign w_obs = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fail,
                    bus.retry_count, bus.lock_lost};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] ov(input logic pr, input logic sr, input logic rd,
                                      input logic fl, input logic [3:0] rc, input logic ll);
        return {pr, sr, rd, fl, rc, ll};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s @edge %0d: got {prst,srst,rdy,fail,retry,lost}=%b required %b",
                     name, edge_n, act, exp);
        else
            n_pass++;
    endtask

    task automatic expect_at(input int dly, input string name, input logic [8:0] v);
        exp_t e;
        e.cyc  = edge_n + dly;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the bench at the negedge where rst was released
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.locked_in = 1'b0;
        #1;
        check("reset_values", w_obs, ov(1, 1, 0, 0, 4'd0, 0));
        wait_neg(3);
        rst = 1'b0;
    endtask

    // monitor: one sample per refclk edge, away from the edge
    initial begin
        edge_n = 0;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == edge_n) begin
                    check(sb[i].name, w_obs, sb[i].val);
                    sb.delete(i);
                end else if (sb[i].cyc < edge_n) begin
                    n_checks++;
                    $display("FAIL %s: expectation for edge %0d never sampled (now %0d)",
                             sb[i].name, sb[i].cyc, edge_n);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.locked_in = 1'b0;

        // normal bring-up: lock 20 cycles after pll_rst falls
        do_reset();
        expect_at(1,  "s1_prst_hold", ov(1, 1, 0, 0, 4'd0, 0));
        expect_at(3,  "s1_prst_last", ov(1, 1, 0, 0, 4'd0, 0));
        expect_at(4,  "s1_prst_fall", ov(0, 1, 0, 0, 4'd0, 0));
        wait_neg(24);
        bus.locked_in = 1'b1;
        expect_at(10, "s1_pre_release", ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(11, "s1_release",     ov(0, 0, 1, 0, 4'd0, 0));
        wait_neg(20);

        // lock loss while running, then full re-sequence
        bus.locked_in = 1'b0;
        expect_at(2,  "s5_still_run", ov(0, 0, 1, 0, 4'd0, 0));
        expect_at(3,  "s5_lock_lost", ov(1, 1, 0, 0, 4'd0, 1));
        expect_at(4,  "s5_lost_pulse_end", ov(1, 1, 0, 0, 4'd0, 0));
        expect_at(6,  "s5_prst_last", ov(1, 1, 0, 0, 4'd0, 0));
        expect_at(7,  "s5_prst_fall", ov(0, 1, 0, 0, 4'd0, 0));
        wait_neg(10);
        bus.locked_in = 1'b1;
        expect_at(10, "s5_pre_release", ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(11, "s5_release",     ov(0, 0, 1, 0, 4'd0, 0));
        wait_neg(15);

        // unstable lock: 5 high, 3 low, then steady
        do_reset();
        wait_neg(10);
        bus.locked_in = 1'b1;
        expect_at(7,  "s2_burst_held", ov(0, 1, 0, 0, 4'd0, 0));
        wait_neg(5);
        bus.locked_in = 1'b0;
        wait_neg(3);
        bus.locked_in = 1'b1;
        expect_at(3,  "s2_no_early_release", ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(10, "s2_pre_release",      ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(11, "s2_release",          ov(0, 0, 1, 0, 4'd0, 0));
        wait_neg(15);

        // three consecutive timeouts end in FAIL
        do_reset();
        expect_at(4,   "s3_wait1",       ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(103, "s3_pre_to1",     ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(104, "s3_timeout1",    ov(1, 1, 0, 0, 4'd1, 0));
        expect_at(107, "s3_repulse_end", ov(1, 1, 0, 0, 4'd1, 0));
        expect_at(108, "s3_wait2",       ov(0, 1, 0, 0, 4'd1, 0));
        expect_at(207, "s3_pre_to2",     ov(0, 1, 0, 0, 4'd1, 0));
        expect_at(208, "s3_timeout2",    ov(1, 1, 0, 0, 4'd2, 0));
        expect_at(212, "s3_wait3",       ov(0, 1, 0, 0, 4'd2, 0));
        expect_at(311, "s3_pre_to3",     ov(0, 1, 0, 0, 4'd2, 0));
        expect_at(312, "s3_fail",        ov(1, 1, 0, 1, 4'd3, 0));
        wait_neg(320);
        bus.locked_in = 1'b1;
        wait_neg(30);
        expect_at(1,   "s3_fail_sticky", ov(1, 1, 0, 1, 4'd3, 0));
        wait_neg(3);

        // two timeouts, then lock: retry_count clears on RUN entry
        do_reset();
        expect_at(208, "s4_timeout2", ov(1, 1, 0, 0, 4'd2, 0));
        wait_neg(230);
        bus.locked_in = 1'b1;
        expect_at(10,  "s4_pre_release", ov(0, 1, 0, 0, 4'd2, 0));
        expect_at(11,  "s4_release",     ov(0, 0, 1, 0, 4'd0, 0));
        wait_neg(15);

        // asynchronous reset in the middle of STABILIZE
        do_reset();
        expect_at(104, "s6_timeout1", ov(1, 1, 0, 0, 4'd1, 0));
        wait_neg(110);
        bus.locked_in = 1'b1;
        wait_neg(5);
        expect_at(1,   "s6_in_stabilize", ov(0, 1, 0, 0, 4'd1, 0));
        wait_neg(1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_rst", w_obs, ov(1, 1, 0, 0, 4'd0, 0));
        wait_neg(2);
        rst = 1'b0;
        expect_at(3,  "s6_restart_prst", ov(1, 1, 0, 0, 4'd0, 0));
        expect_at(4,  "s6_restart_wait", ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(12, "s6_pre_release",  ov(0, 1, 0, 0, 4'd0, 0));
        expect_at(13, "s6_release",      ov(0, 0, 1, 0, 4'd0, 0));
        wait_neg(16);

        for (int i = 0; i < sb.size(); i++) begin
            n_checks++;
            $display("FAIL %s: expectation for edge %0d still pending at edge %0d",
                     sb[i].name, sb[i].cyc, edge_n);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
